sram_access_ctrl: RTL and testbench

Sequencer for one mixed-signal SRAM bank. Accepts a single read or write request from the digital side, then drives the analog-domain control rails of the array as real-valued levels: row-select bus into the row decoder, precharge, wordline enable, write drivers and sense-amp enable. It samples the real-valued bitline sense outputs back into logic read data. It sits between the bank's digital request port and the row decoder, bitline drivers and sense amps.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_access_ctrl_if.sv | 28 ++
 rtl/sram_phase_timer.sv | 27 ++
 rtl/sram_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the SRAM bank: rail levels seen by
// the decoder, drivers and sense amps, plus the access sequencer states.
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WL,
    S_SENSE,
    S_DONE
  } state_t;

  function automatic real level(input logic b);
    return b ? VDD : VSS;
  endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Digital request port of the SRAM bank sequencer.
// Handshake: a request transfers on a rising edge where req=1 and ready=1;
// done pulses for one cycle at completion, with err and rdata valid alongside.
interface sram_access_ctrl_if #(
  parameter int RW   = 4,
  parameter int COLS = 8
);

  logic            req;
  logic            we;
  logic [RW-1:0]   addr;
  logic [COLS-1:0] wdata;
  logic            ready;
  logic            done;
  logic            err;
  logic [COLS-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, done, err, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, done, err, rdata
  );

endinterface

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that times the precharge and wordline phases; holds
// at zero and flags it.
module sram_phase_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_value,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-request sequencer for one SRAM bank: precharge, wordline, write drive
// or sense, then a one-cycle done. All outputs are registered from next state.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int ROWS       = 16,
  parameter int COLS       = 8,
  parameter int PRE_CYCLES = 2,
  parameter int WL_CYCLES  = 2,
  localparam int RW        = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  sram_access_ctrl_if.slave  bus,
  output real                row_sel [0:RW-1],
  output real                pre_en,
  output real                wl_en,
  output real                wr_en,
  output real                bl_drv [0:COLS-1],
  output real                sae,
  input  real                bl_sense [0:COLS-1],
  output state_t             o_dbg_state
);

  localparam int MAX_CYC = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] PRE_LOAD = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] WL_LOAD  = CW'(WL_CYCLES - 1);
  localparam logic [RW:0]   ROWS_LIM = (RW + 1)'(ROWS);

  state_t          r_state;
  state_t          w_next;
  logic            r_we;
  logic [RW-1:0]   r_addr;
  logic [COLS-1:0] r_wdata;

  logic            r_ready;
  logic            r_done;
  logic            r_err;
  logic [COLS-1:0] r_rdata;
  real             r_row_sel [0:RW-1];
  real             r_pre_en;
  real             r_wl_en;
  real             r_wr_en;
  real             r_bl_drv [0:COLS-1];
  real             r_sae;

  logic            w_accept;
  logic            w_oor;
  logic            w_zero;
  logic            w_load;
  logic [CW-1:0]   w_load_val;
  logic            w_we_src;
  logic [RW-1:0]   w_addr_src;
  logic [COLS-1:0] w_wdata_src;
  logic            w_row_on;
  logic            w_drive;

  sram_phase_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_accept = (r_state == S_IDLE) && bus.req;
    w_oor    = w_accept && ({1'b0, bus.addr} >= ROWS_LIM);
    w_next   = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_oor ? S_DONE : S_PRE;
      S_PRE:   if (w_zero) w_next = S_WL;
      S_WL:    if (w_zero) w_next = r_we ? S_DONE : S_SENSE;
      S_SENSE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_load     = (w_next != r_state);
    w_load_val = (w_next == S_WL) ? WL_LOAD : PRE_LOAD;
  end

  // Output registers look at next state, so the request fields must bypass
  // the capture registers on the accept edge.
  always_comb begin
    w_we_src    = w_accept ? bus.we    : r_we;
    w_addr_src  = w_accept ? bus.addr  : r_addr;
    w_wdata_src = w_accept ? bus.wdata : r_wdata;
    w_row_on    = (w_next == S_PRE) || (w_next == S_WL) || (w_next == S_SENSE);
    w_drive     = (w_next == S_WL) && w_we_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= bus.we;
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_pre_en <= VSS;
      r_wl_en  <= VSS;
      r_wr_en  <= VSS;
      r_sae    <= VSS;
      for (int i = 0; i < RW; i++) r_row_sel[i] <= VSS;
      for (int i = 0; i < COLS; i++) r_bl_drv[i] <= VSS;
    end else begin
      r_ready  <= (w_next == S_IDLE);
      r_done   <= (w_next == S_DONE);
      r_err    <= w_oor;
      r_pre_en <= level(w_next == S_PRE);
      r_wl_en  <= level((w_next == S_WL) || (w_next == S_SENSE));
      r_wr_en  <= level(w_drive);
      r_sae    <= level(w_next == S_SENSE);
      for (int i = 0; i < RW; i++) r_row_sel[i] <= level(w_row_on && w_addr_src[i]);
      for (int i = 0; i < COLS; i++) r_bl_drv[i] <= level(w_drive && w_wdata_src[i]);
      if (r_state == S_SENSE) begin
        for (int i = 0; i < COLS; i++) r_rdata[i] <= (bl_sense[i] >= VTH);
      end
    end
  end

  assign bus.ready   = r_ready;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.rdata   = r_rdata;
  assign row_sel     = r_row_sel;
  assign pre_en      = r_pre_en;
  assign wl_en       = r_wl_en;
  assign wr_en       = r_wr_en;
  assign bl_drv      = r_bl_drv;
  assign sae         = r_sae;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: table of read/write transactions with per-cycle
// rail checks, plus held-request, mid-operation reset and out-of-range cases.
module tb_sram_access_ctrl;
  import sram_pkg::*;

  localparam int COLS = 8;
  localparam int RW   = 4;
  localparam int PRE  = 2;
  localparam int WLC  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sram_access_ctrl_if #(.RW(RW), .COLS(COLS)) bus16 ();
  sram_access_ctrl_if #(.RW(RW), .COLS(COLS)) bus12 ();

  real    row_sel16 [0:RW-1];
  real    drv16 [0:COLS-1];
  real    pre16, wl16, wr16, sae16;
  real    row_sel12 [0:RW-1];
  real    drv12 [0:COLS-1];
  real    pre12, wl12, wr12, sae12;
  real    bl_sense [0:COLS-1];
  state_t st16, st12;

  sram_access_ctrl #(.ROWS(16), .COLS(COLS), .PRE_CYCLES(PRE), .WL_CYCLES(WLC)) dut (
    .clk(clk), .rst(rst), .bus(bus16), .row_sel(row_sel16), .pre_en(pre16),
    .wl_en(wl16), .wr_en(wr16), .bl_drv(drv16), .sae(sae16),
    .bl_sense(bl_sense), .o_dbg_state(st16)
  );

  sram_access_ctrl #(.ROWS(12), .COLS(COLS), .PRE_CYCLES(PRE), .WL_CYCLES(WLC)) dut12 (
    .clk(clk), .rst(rst), .bus(bus12), .row_sel(row_sel12), .pre_en(pre12),
    .wl_en(wl12), .wr_en(wr12), .bl_drv(drv12), .sae(sae12),
    .bl_sense(bl_sense), .o_dbg_state(st12)
  );

  // ---------------- scoreboard ----------------
  logic [COLS-1:0] exp_q[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_r(input string name, input real act, input real exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0.3f expected %0.3f", name, act, exp);
    end
  endtask

  function automatic real lv(input logic b);
    return b ? 1.5 : 0.0;
  endfunction

  task automatic chk_rails16(input string tag, input bit p, input bit w, input bit wr,
                             input bit s, input bit row_on, input logic [RW-1:0] a,
                             input logic [COLS-1:0] d);
    chk_r({tag, " pre_en"}, pre16, lv(p));
    chk_r({tag, " wl_en"}, wl16, lv(w));
    chk_r({tag, " wr_en"}, wr16, lv(wr));
    chk_r({tag, " sae"}, sae16, lv(s));
    for (int i = 0; i < RW; i++) chk_r($sformatf("%s row_sel[%0d]", tag, i), row_sel16[i], lv(row_on && a[i]));
    for (int i = 0; i < COLS; i++) chk_r($sformatf("%s bl_drv[%0d]", tag, i), drv16[i], lv(wr && d[i]));
  endtask

  task automatic set_sense(input logic [COLS-1:0] pat, input real hi, input real lo);
    for (int i = 0; i < COLS; i++) bl_sense[i] = pat[i] ? hi : lo;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit              we;
    logic [RW-1:0]   addr;
    logic [COLS-1:0] wdata;
    logic [COLS-1:0] pat;
    real             hi;
    real             lo;
    logic [COLS-1:0] exp_rdata;
    int              exp_lat;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(input bit we, input logic [RW-1:0] a, input logic [COLS-1:0] wd,
                              input logic [COLS-1:0] pat, input real hi, input real lo,
                              input logic [COLS-1:0] er, input int lat);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.pat = pat;
    v.hi = hi; v.lo = lo; v.exp_rdata = er; v.exp_lat = lat;
    return v;
  endfunction

  // ---------------- driver: one transaction on the 16-row bank ----------------
  // Called at a falling edge with the controller idle; returns at the falling
  // edge one cycle after done, again idle.
  task automatic do_txn(input string tag, input vec_t v);
    int n;
    bit seen;
    logic [COLS-1:0] exp_rd;
    chk1({tag, " ready before accept"}, bus16.ready, 1'b1);
    set_sense(v.pat, v.hi, v.lo);
    bus16.req   = 1'b1;
    bus16.we    = v.we;
    bus16.addr  = v.addr;
    bus16.wdata = v.wdata;
    exp_q.push_back(v.exp_rdata);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      bus16.req = 1'b0;
      if (bus16.done) begin
        seen = 1'b1;
        exp_rd = exp_q.pop_front();
        chk_int({tag, " latency"}, n, v.exp_lat);
        chk1({tag, " err"}, bus16.err, 1'b0);
        chk1({tag, " ready at done"}, bus16.ready, 1'b0);
        chk8({tag, " rdata"}, bus16.rdata, exp_rd);
        chk_rails16({tag, " done"}, 0, 0, 0, 0, 0, '0, '0);
      end else begin
        chk1($sformatf("%s ready busy c%0d", tag, n), bus16.ready, 1'b0);
        if (n <= PRE)
          chk_rails16($sformatf("%s pre c%0d", tag, n), 1, 0, 0, 0, 1, v.addr, v.wdata);
        else if (n <= PRE + WLC)
          chk_rails16($sformatf("%s wl c%0d", tag, n), 0, 1, v.we, 0, 1, v.addr, v.wdata);
        else
          chk_rails16($sformatf("%s sense c%0d", tag, n), 0, 1, 0, 1, 1, v.addr, v.wdata);
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s done timeout: no done within %0d cycles, expected %0d", tag, n, v.exp_lat);
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    chk1({tag, " ready after"}, bus16.ready, 1'b1);
    chk1({tag, " done after"}, bus16.done, 1'b0);
    chk8({tag, " rdata held"}, bus16.rdata, v.exp_rdata);
    chk_rails16({tag, " idle"}, 0, 0, 0, 0, 0, '0, '0);
  endtask

  // Out-of-range access on the 12-row bank: done+err one cycle after accept.
  task automatic oor12(input string tag, input bit we, input logic [RW-1:0] a,
                       input logic [COLS-1:0] held);
    bus12.req = 1'b1; bus12.we = we; bus12.addr = a; bus12.wdata = 8'hFF;
    @(negedge clk);
    bus12.req = 1'b0;
    chk1({tag, " done"}, bus12.done, 1'b1);
    chk1({tag, " err"}, bus12.err, 1'b1);
    chk1({tag, " ready"}, bus12.ready, 1'b0);
    chk8({tag, " rdata"}, bus12.rdata, held);
    chk_r({tag, " pre_en"}, pre12, VSS);
    chk_r({tag, " wl_en"}, wl12, VSS);
    chk_r({tag, " wr_en"}, wr12, VSS);
    chk_r({tag, " sae"}, sae12, VSS);
    @(negedge clk);
    chk1({tag, " done after"}, bus12.done, 1'b0);
    chk1({tag, " err after"}, bus12.err, 1'b0);
    chk1({tag, " ready after"}, bus12.ready, 1'b1);
    chk_r({tag, " pre_en after"}, pre12, VSS);
    chk_r({tag, " wl_en after"}, wl12, VSS);
  endtask

  initial begin
    int n;
    int done_cnt;
    bit seen;
    logic [COLS-1:0] exp_rd;

    rst = 1'b1;
    bus16.req = 1'b0; bus16.we = 1'b0; bus16.addr = '0; bus16.wdata = '0;
    bus12.req = 1'b0; bus12.we = 1'b0; bus12.addr = '0; bus12.wdata = '0;
    set_sense('0, 1.2, 0.3);

    vecs[0] = mk(1'b1, 4'd5,  8'hA5, 8'h00, 1.2, 0.3,  8'h00, 5);
    vecs[1] = mk(1'b0, 4'd15, 8'h00, 8'h55, 1.2, 0.3,  8'h55, 6);
    vecs[2] = mk(1'b1, 4'd0,  8'hFF, 8'h00, 1.2, 0.3,  8'h55, 5);
    vecs[3] = mk(1'b0, 4'd3,  8'h00, 8'hA3, 1.2, 0.3,  8'hA3, 6);
    vecs[4] = mk(1'b0, 4'd9,  8'h00, 8'hF0, 0.8, 0.79, 8'hF0, 6);
    vecs[5] = mk(1'b1, 4'd15, 8'h3C, 8'h00, 1.2, 0.3,  8'hF0, 5);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state held through idle cycles.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk1($sformatf("reset ready c%0d", c), bus16.ready, 1'b1);
      chk1($sformatf("reset done c%0d", c), bus16.done, 1'b0);
      chk1($sformatf("reset err c%0d", c), bus16.err, 1'b0);
      chk8($sformatf("reset rdata c%0d", c), bus16.rdata, 8'h00);
      chk_int($sformatf("reset state c%0d", c), int'(st16), int'(S_IDLE));
      chk_rails16($sformatf("reset c%0d", c), 0, 0, 0, 0, 0, '0, '0);
    end

    for (int i = 0; i < 6; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back reads with req held high: accepts every 7 cycles.
    set_sense(8'h3C, 1.2, 0.3);
    bus16.req = 1'b1; bus16.we = 1'b0; bus16.addr = 4'd7;
    done_cnt = 0;
    for (int k = 0; k < 28; k++) begin
      if (k > 0) @(negedge clk);
      chk1($sformatf("b2b ready k%0d", k), bus16.ready, (k % 7) == 0);
      chk1($sformatf("b2b done k%0d", k), bus16.done, (k % 7) == 6);
      if ((k % 7) == 0) exp_q.push_back(8'h3C);
      if (bus16.done) begin
        done_cnt++;
        if (exp_q.size() > 0) begin
          exp_rd = exp_q.pop_front();
          chk8($sformatf("b2b rdata k%0d", k), bus16.rdata, exp_rd);
        end
      end
      if (k == 27) bus16.req = 1'b0;
    end
    @(negedge clk);
    chk1("b2b ready end", bus16.ready, 1'b1);
    chk_int("b2b done count", done_cnt, 4);
    chk_int("b2b queue empty", exp_q.size(), 0);
    exp_q.delete();

    // Reset during the wordline phase of a write.
    bus16.req = 1'b1; bus16.we = 1'b1; bus16.addr = 4'd9; bus16.wdata = 8'h0F;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      bus16.req = 1'b0;
    end
    chk_r("rstwl wl_en before", wl16, VDD);
    chk_r("rstwl wr_en before", wr16, VDD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_int("rstwl state", int'(st16), int'(S_IDLE));
    chk1("rstwl ready", bus16.ready, 1'b1);
    chk1("rstwl done", bus16.done, 1'b0);
    chk8("rstwl rdata cleared", bus16.rdata, 8'h00);
    chk_rails16("rstwl", 0, 0, 0, 0, 0, '0, '0);
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus16.done) done_cnt++;
    end
    chk_int("rstwl no done pulse", done_cnt, 0);
    do_txn("post-rst read", mk(1'b0, 4'd6, 8'h00, 8'h99, 1.2, 0.3, 8'h99, 6));

    // 12-row bank: a good read, then out-of-range reads/writes.
    set_sense(8'h55, 1.2, 0.3);
    bus12.req = 1'b1; bus12.we = 1'b0; bus12.addr = 4'd11;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(negedge clk);
      n++;
      bus12.req = 1'b0;
      if (bus12.done) seen = 1'b1;
    end
    chk_int("r12 latency", n, 6);
    chk1("r12 err", bus12.err, 1'b0);
    chk8("r12 rdata", bus12.rdata, 8'h55);
    @(negedge clk);
    set_sense(8'hAA, 1.2, 0.3);
    oor12("oor13", 1'b0, 4'd13, 8'h55);
    oor12("oor12", 1'b0, 4'd12, 8'h55);
    oor12("oor14w", 1'b1, 4'd14, 8'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
